// File: rtl/one2two_sync.sv
// rtl/one2two_sync.sv - framed 1-bit to 2-bit symbol receiver with sync-word lock FSM
// Sync word trails each payload; HUNT/CONFIRM/LOCK flywheels through isolated sync misses.
module one2two_sync #(
  parameter int                  SYNC_LEN     = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 8'b1110_0100,
  parameter int                  PAYLOAD_BITS = 16,
  parameter int                  LOCK_CNT     = 3,
  parameter int                  UNLOCK_CNT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_data,
  output logic [1:0] out_data,
  output logic       out_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int FRAME_BITS = SYNC_LEN + PAYLOAD_BITS;
  localparam int PW = $clog2(FRAME_BITS);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  localparam logic [PW-1:0] LAST_POS = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] PAY_END  = PW'(PAYLOAD_BITS);
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam logic [HW-1:0] HIT_TGT  = HW'(LOCK_CNT);
  localparam logic [HW-1:0] ONE_H    = HW'(1);
  localparam logic [MW-1:0] MISS_TGT = MW'(UNLOCK_CNT);
  localparam logic [MW-1:0] ONE_M    = MW'(1);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCK} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       pos, pos_nxt;
  logic [HW-1:0]       hit_cnt, hit_nxt;
  logic [MW-1:0]       miss_cnt, miss_nxt;
  logic                err_nxt;
  logic [SYNC_LEN-1:0] sr;
  logic [SYNC_LEN-1:0] win;
  logic                hit;
  logic                at_check;
  logic [PW-1:0]       pos_inc;
  logic                msb;
  logic                in_payload;
  logic                keep_lock;

  // Window includes the bit being sampled now so a hit acts on this very edge.
  assign win      = {sr[SYNC_LEN-2:0], in_data};
  assign hit      = (win == SYNC_WORD);
  assign at_check = (pos == LAST_POS);
  assign pos_inc  = at_check ? '0 : pos + ONE_P;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      pos      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    hit_nxt   = hit_cnt;
    miss_nxt  = miss_cnt;
    err_nxt   = 1'b0;
    case (state)
      HUNT: begin
        if (hit) begin
          pos_nxt   = '0;
          hit_nxt   = ONE_H;
          miss_nxt  = '0;
          state_nxt = (LOCK_CNT == 1) ? LOCK : CONFIRM;
        end
      end
      CONFIRM: begin
        pos_nxt = pos_inc;
        if (at_check) begin
          if (hit) begin
            hit_nxt = hit_cnt + ONE_H;
            if (hit_nxt == HIT_TGT) begin
              state_nxt = LOCK;
              miss_nxt  = '0;
            end
          end else begin
            state_nxt = HUNT;
          end
        end
      end
      LOCK: begin
        pos_nxt = pos_inc;
        if (at_check) begin
          if (hit) begin
            miss_nxt = '0;
          end else begin
            miss_nxt = miss_cnt + ONE_M;
            err_nxt  = 1'b1;
            if (miss_nxt == MISS_TGT) state_nxt = HUNT;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Symbols only come out while lock holds across this edge; a half pair is dropped on exit.
  assign in_payload = (pos < PAY_END);
  assign keep_lock  = (state == LOCK) && (state_nxt == LOCK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr          <= '0;
      msb         <= 1'b0;
      out_data    <= 2'b00;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      sr          <= win;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= err_nxt;
      if (keep_lock && in_payload) begin
        if (!pos[0]) begin
          msb <= in_data;
        end else begin
          out_data    <= {msb, in_data};
          out_valid   <= 1'b1;
          frame_start <= (pos == ONE_P);
        end
      end
    end
  end

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_one2two_sync.sv
// tb/tb_one2two_sync.sv - directed bench for one2two_sync with a bit-history reference model
module tb_one2two_sync;

  localparam int         SL = 8;
  localparam logic [7:0] SW = 8'hE4;
  localparam int         PB = 16;
  localparam int         FB = SL + PB;
  localparam int         LC = 3;
  localparam int         UC = 2;
  localparam int         M_HUNT = 0, M_CONF = 1, M_LOCK = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_data = 1'b0;
  logic [1:0] out_data;
  logic       out_valid, frame_start, locked, sync_err;

  always #5 clk = ~clk;

  one2two_sync #(
    .SYNC_LEN(SL), .SYNC_WORD(SW), .PAYLOAD_BITS(PB), .LOCK_CNT(LC), .UNLOCK_CNT(UC)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .out_data(out_data),
    .out_valid(out_valid), .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remembers every bit since reset and measures frame phase
  // as the distance from the bit that completed the aligning sync word.
  logic       hist[$];
  int         m_mode, m_anchor, m_hits, m_miss;
  logic       m_valid, m_fs, m_err;
  logic [1:0] m_data;
  bit         chk_en = 1'b0;

  task automatic model_reset();
    hist.delete();
    m_mode = M_HUNT; m_anchor = 0; m_hits = 0; m_miss = 0;
    m_valid = 1'b0; m_fs = 1'b0; m_err = 1'b0; m_data = 2'b00;
  endtask

  task automatic model_step(input logic b);
    int k, ph;
    logic [7:0] w;
    hist.push_back(b);
    k = hist.size() - 1;
    w = '0;
    for (int i = 0; i < SL; i++) if (k - i >= 0) w[i] = hist[k-i];
    m_valid = 1'b0; m_fs = 1'b0; m_err = 1'b0;
    if (m_mode == M_HUNT) begin
      if (w == SW) begin
        m_anchor = k; m_hits = 1; m_miss = 0;
        m_mode = (LC == 1) ? M_LOCK : M_CONF;
      end
    end else begin
      ph = (k - m_anchor - 1) % FB;
      if (m_mode == M_LOCK && ph < PB && (ph % 2) == 1) begin
        m_valid = 1'b1;
        m_data  = {hist[k-1], hist[k]};
        m_fs    = (ph == 1);
      end
      if (ph == FB - 1) begin
        if (m_mode == M_CONF) begin
          if (w == SW) begin
            m_hits++;
            if (m_hits == LC) begin m_mode = M_LOCK; m_miss = 0; end
          end else m_mode = M_HUNT;
        end else begin
          if (w == SW) m_miss = 0;
          else begin
            m_miss++; m_err = 1'b1;
            if (m_miss == UC) m_mode = M_HUNT;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_frame_start", frame_start, m_fs);
      chk("cyc_out_data", out_data, m_data);
      chk("cyc_locked", locked, (m_mode == M_LOCK));
      chk("cyc_sync_err", sync_err, m_err);
    end
  end

  int         f_valid, f_fs, f_err;
  logic [1:0] f_syms[$];

  task automatic send_bit(input logic b);
    in_data = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
    if (out_valid === 1'b1) begin f_valid++; f_syms.push_back(out_data); end
    if (frame_start === 1'b1) f_fs++;
    if (sync_err === 1'b1) f_err++;
  endtask

  task automatic send_frame(input logic [15:0] pay, input logic [7:0] syn);
    f_valid = 0; f_fs = 0; f_err = 0; f_syms.delete();
    for (int i = 15; i >= 0; i--) send_bit(pay[i]);
    for (int i = 7; i >= 0; i--) send_bit(syn[i]);
  endtask

  task automatic chk_syms(input string tag, input logic [15:0] pay);
    logic [1:0] e;
    chk({tag, "_count"}, f_syms.size(), 8);
    for (int i = 0; i < 8 && i < f_syms.size(); i++) begin
      e = pay[15-2*i -: 2];
      chk($sformatf("%s_sym%0d", tag, i), f_syms[i], e);
    end
  endtask

  task automatic chk_outputs_low(input string tag);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
  endtask

  logic [1:0]  exp_syms [8] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd3};
  logic [4:0]  prefix = 5'b01101;
  logic [15:0] rnd;
  int          pre_lock_valid;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_outputs_low("reset");
    reset = 1'b1;
    chk_en = 1'b1;

    // Clean acquisition
    for (int i = 4; i >= 0; i--) send_bit(prefix[i]);
    send_frame(16'hA5C3, 8'hE4); chk("acq_locked_f1", locked, 0);
    pre_lock_valid = f_valid;
    send_frame(16'hA5C3, 8'hE4); chk("acq_locked_f2", locked, 0);
    pre_lock_valid += f_valid;
    send_frame(16'hA5C3, 8'hE4); chk("acq_locked_f3", locked, 1);
    pre_lock_valid += f_valid;
    chk("acq_no_early_symbols", pre_lock_valid, 0);
    send_frame(16'hA5C3, 8'hE4);
    chk("acq_valid_cnt", f_valid, 8);
    chk("acq_fs_cnt", f_fs, 1);
    for (int i = 0; i < 8 && i < f_syms.size(); i++) chk($sformatf("acq_sym%0d", i), f_syms[i], exp_syms[i]);

    // Flywheel over one bad sync
    send_frame(16'hA5C3, 8'h00);
    chk("fly_err_cnt", f_err, 1); chk("fly_locked", locked, 1); chk("fly_valid_cnt", f_valid, 8);
    send_frame(16'h3C5A, 8'hE4);
    chk("fly_next_err", f_err, 0); chk_syms("fly_next", 16'h3C5A);

    // Lock loss after two bad syncs, then reacquisition
    send_frame(16'hA5C3, 8'h00); chk("loss_err1", f_err, 1); chk("loss_locked1", locked, 1);
    send_frame(16'hA5C3, 8'h00); chk("loss_err2", f_err, 1); chk("loss_locked2", locked, 0);
    chk("loss_valid_before", f_valid, 8);
    send_frame(16'hA5C3, 8'hE4); chk("reacq_valid_r1", f_valid, 0); chk("reacq_locked_r1", locked, 0);
    send_frame(16'hA5C3, 8'hE4); chk("reacq_locked_r2", locked, 0);
    send_frame(16'hA5C3, 8'hE4); chk("reacq_locked_r3", locked, 1);

    // Asynchronous reset mid-frame, right after a symbol strobe
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    chk("mid_valid_before_reset", out_valid, 1);
    #2 reset = 1'b0;
    chk_en = 1'b0;
    #1 chk_outputs_low("async_reset");
    @(negedge clk); @(negedge clk);
    model_reset();
    reset = 1'b1;
    chk_en = 1'b1;

    // False sync inside payload while hunting
    send_frame(16'h00E4, 8'hE4); chk("false_locked_f1", locked, 0);
    pre_lock_valid = f_valid;
    send_frame(16'hA5C3, 8'hE4); chk("false_locked_f2", locked, 0);
    pre_lock_valid += f_valid;
    send_frame(16'hA5C3, 8'hE4); chk("false_locked_f3", locked, 0);
    pre_lock_valid += f_valid;
    send_frame(16'hA5C3, 8'hE4); chk("false_locked_f4", locked, 1);
    pre_lock_valid += f_valid;
    chk("false_no_early_symbols", pre_lock_valid, 0);

    // Round trip of arbitrary symbol streams once locked
    for (int f = 0; f < 4; f++) begin
      rnd = 16'($urandom);
      send_frame(rnd, 8'hE4);
      chk_syms($sformatf("rt%0d", f), rnd);
      chk($sformatf("rt%0d_fs", f), f_fs, 1);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/one2two_sync.md
# one2two_sync

Serial-to-parallel receiver for the 1-bit link driven by the `two2one` serializer. It recovers 2-bit symbols from the bit stream, with the first bit received taken as the MSB. Symbol-pair phase comes from a framing sync word, and a HUNT/CONFIRM/LOCK state machine flywheels through isolated sync errors. It sits at the receive end of the link and feeds 2-bit symbols with a valid strobe to the downstream decoder.

## Interface
- SYNC_LEN, 8: sync word length in bits (≥2).
- SYNC_WORD, 8'b1110_0100: sync pattern, MSB received first; must be nonzero.
- PAYLOAD_BITS, 16: payload bits per frame; even, ≥2.
- LOCK_CNT, 3: consecutive sync hits needed to declare lock, counting the first hit (≥1).
- UNLOCK_CNT, 2: consecutive missed syncs in LOCK that drop lock (≥1).
- clk  in  1  bit clock; one serial bit per rising edge.
- reset  in  1  reset, asynchronous, active-low.
- in_data  in  1  serial bit, sampled every rising edge of clk.
- out_data  out  2  recovered symbol, {first bit, second bit}.
- out_valid  out  1  one-cycle pulse; out_data holds a new symbol.
- frame_start  out  1  pulses together with out_valid on the first symbol of each frame.
- locked  out  1  high while in LOCK.
- sync_err  out  1  one-cycle pulse on a missed sync check while in LOCK.

## Operation
- FRAME_BITS = SYNC_LEN + PAYLOAD_BITS. Each frame on the wire is PAYLOAD_BITS payload bits followed by SYNC_LEN sync bits.
- Shift register sr (SYNC_LEN bits). On every edge, sr <= {sr[SYNC_LEN-2:0], in_data}.
- hit is computed combinationally: hit = ({sr[SYNC_LEN-2:0], in_data} == SYNC_WORD).
- Position counter pos runs 0..FRAME_BITS-1 and wraps to 0. pos = 0 on the edge that samples payload bit 0. Sync check happens at pos == FRAME_BITS-1.
- HUNT:
  - hit at any edge → pos <= 0, hit count <= 1, go to CONFIRM.
  - If LOCK_CNT = 1, go to LOCK instead.
- CONFIRM, at the check edge:
  - hit → increment hit count; on reaching LOCK_CNT, go to LOCK and clear the miss count.
  - miss → HUNT.
- LOCK, at the check edge:
  - hit → clear the miss count.
  - miss → increment miss count and pulse sync_err. On reaching UNLOCK_CNT, go to HUNT; otherwise stay in LOCK and keep pos running.
- No hits are evaluated at non-check edges in CONFIRM or LOCK.
- Payload output, only while in LOCK:
  - Even pos < PAYLOAD_BITS: latch in_data into the MSB holding register.
  - Odd pos < PAYLOAD_BITS: out_data <= {msb, in_data} and out_valid <= 1.
  - pos == 1 also sets frame_start <= 1.
- Sync bits are never emitted as symbols.
- Leaving LOCK stops output from the next edge. A symbol pair already half-collected is discarded.
- locked = (state == LOCK).

## Timing
- Reset values: out_data 2'b00, out_valid 0, frame_start 0, locked 0, sync_err 0, state HUNT, sr 0, pos 0, all counts 0.
- All outputs are registered. Symbol latency: out_valid is high in the cycle after the edge that sampled the symbol's second bit.
- Symbol rate when locked: one out_valid pulse every 2 cycles across payload. No pulses during the SYNC_LEN sync bits.
- locked rises in the cycle after the LOCK_CNT-th hit edge; the first symbol follows 2 cycles later.
- locked falls in the cycle after the UNLOCK_CNT-th miss edge. sync_err pulses in that same cycle.
- On a simultaneous LOCK exit and odd payload position, no symbol is emitted (this is unreachable, since checks occur only at the sync position).
- Asynchronous reset mid-frame forces every output low immediately and restarts from HUNT; no partial symbol survives.
- A false hit in HUNT inside payload data is allowed. CONFIRM rejects it at the next check position.

## Test plan
- **Reset:** assert reset mid-stream → all outputs 0 within the same cycle; after release, locked stays 0 until 3 valid frames are received.
- **Clean acquisition:** prefix 5 random bits, then frames of payload 16'hA5C3 + sync 8'hE4 (defaults) → locked rises after the 3rd sync.
  - Following frames yield symbols 2,2,1,1,3,0,0,3 with 8 out_valid pulses per frame.
  - frame_start fires with the first symbol.
- **False sync in payload:** payload 16'h00E4 while hunting → CONFIRM entered early, rejected at the next check, returns to HUNT, then locks on the true alignment with no symbols before locked.
- **Flywheel:** locked, corrupt 1 sync word → sync_err pulses once, locked stays 1, all 8 symbols of every frame still emitted and correct.
- **Lock loss:** locked, corrupt 2 consecutive syncs → sync_err on each, locked falls after the 2nd, out_valid stops, reacquisition takes 3 clean frames.
- **Round trip:** `two2one` feeding this block with framed symbols → out_data reproduces the symbol sequence given to `two2one` once locked.
